// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word collector and its serial receiver.
package uart_pkg;

  localparam int MAX_BYTES            = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_READY,
    ST_CHECK_ZERO,
    ST_WAIT_BYTE,
    ST_STORE,
    ST_DONE
  } collector_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
    return (n > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : n;
  endfunction

endpackage

// File: rtl/uart_receiver.sv
// 8N1 UART deframer: synchronizes RxD, validates the start bit at half a bit period,
// samples data and stop bits at mid-bit, and pulses valid or frame_err per frame.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  rx_state_t     r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_bit_idx, w_bit_idx_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [7:0]    r_data, w_data_next;
  logic          r_valid, w_valid_next;
  logic          r_frame_err, w_frame_err_next;
  logic          r_rxd_meta, r_rxd_sync, r_rxd_prev;

  // Synchronizer resets to the idle-high line level so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= RxD;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt + 1'b1;
    w_bit_idx_next   = r_bit_idx;
    w_shift_next     = r_shift;
    w_data_next      = r_data;
    w_valid_next     = 1'b0;
    w_frame_err_next = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_next = '0;
        if (r_rxd_prev && !r_rxd_sync) w_state_next = RX_START;
      end
      RX_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = r_rxd_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_next     = '0;
          w_shift_next   = {r_rxd_sync, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_next   = '0;
          w_state_next = RX_IDLE;
          if (r_rxd_sync) begin
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
          end else begin
            w_frame_err_next = 1'b1;
          end
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;

endmodule

// File: rtl/rx_word_collector.sv
// Collects 0..4 UART bytes (LSB byte first) into a 32-bit word after a start request.
// Optional inter-byte timeout enabled by defining RX_TIMEOUT_EN.
module rx_word_collector
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RxD,
  input  logic        start,
  input  logic [2:0]  bytes,
  output logic        busy,
  output logic [31:0] word,
  output logic        valid,
  output logic        frame_err,
  output logic        timeout
);

  collector_state_t r_state, w_state_next;
  logic [2:0]       r_count, w_count_next;
  logic [1:0]       r_idx, w_idx_next;
  logic [31:0]      r_acc, w_acc_next;
  logic [31:0]      r_word, w_word_next;
  logic [7:0]       r_byte, w_byte_next;
  logic             r_valid, w_valid_next;
  logic             r_frame_err, w_frame_err_next;
  logic             r_timeout, w_timeout_next;
  logic [MAX_BYTES-1:0] w_lane_sel;
  logic [7:0]       w_rx_data;
  logic             w_rx_valid, w_rx_frame_err;
  logic             w_to_hit;

  uart_receiver #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .RxD       (RxD),
    .data      (w_rx_data),
    .valid     (w_rx_valid),
    .frame_err (w_rx_frame_err)
  );

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_act_meta, r_act_sync, r_act_prev;

  // Private synchronizer so any RxD edge, even a false start, restarts the idle count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_meta <= 1'b1;
      r_act_sync <= 1'b1;
      r_act_prev <= 1'b1;
      r_to_cnt   <= '0;
    end else begin
      r_act_meta <= RxD;
      r_act_sync <= r_act_meta;
      r_act_prev <= r_act_sync;
      if (r_state != ST_WAIT_BYTE || (r_act_sync ^ r_act_prev)) r_to_cnt <= '0;
      else                                                      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_to_hit = (r_state == ST_WAIT_BYTE) && (r_to_cnt == TW'(TIMEOUT_CLKS - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CLKS > 0);
  assign w_to_hit             = 1'b0;
`endif

  for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
    assign w_lane_sel[gi] = (r_state == ST_STORE) && (r_idx == 2'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_READY;
      r_count     <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_word      <= '0;
      r_byte      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_idx       <= w_idx_next;
      r_acc       <= w_acc_next;
      r_word      <= w_word_next;
      r_byte      <= w_byte_next;
      r_valid     <= w_valid_next;
      r_frame_err <= w_frame_err_next;
      r_timeout   <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_idx_next       = r_idx;
    w_acc_next       = r_acc;
    w_word_next      = r_word;
    w_byte_next      = r_byte;
    w_valid_next     = 1'b0;
    w_frame_err_next = 1'b0;
    w_timeout_next   = 1'b0;
    case (r_state)
      ST_READY: begin
        // Receiver bytes arriving here are simply not looked at.
        if (start) begin
          w_count_next = clamp_bytes(bytes);
          w_idx_next   = '0;
          w_acc_next   = '0;
          w_state_next = ST_CHECK_ZERO;
        end
      end
      ST_CHECK_ZERO: w_state_next = (r_count == 3'd0) ? ST_DONE : ST_WAIT_BYTE;
      ST_WAIT_BYTE: begin
        if (w_rx_valid) begin
          w_byte_next  = w_rx_data;
          w_state_next = ST_STORE;
        end else if (w_rx_frame_err) begin
          w_frame_err_next = 1'b1;
          w_state_next     = ST_READY;
        end else if (w_to_hit) begin
          w_timeout_next = 1'b1;
          w_state_next   = ST_READY;
        end
      end
      ST_STORE: begin
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (w_lane_sel[i]) w_acc_next[8*i +: 8] = r_byte;
        end
        w_idx_next   = r_idx + 2'd1;
        w_count_next = r_count - 3'd1;
        w_state_next = ST_CHECK_ZERO;
      end
      ST_DONE: begin
        w_word_next  = r_acc;
        w_valid_next = 1'b1;
        w_state_next = ST_READY;
      end
      default: w_state_next = ST_READY;
    endcase
  end

  assign busy      = (r_state != ST_READY);
  assign word      = r_word;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
`ifdef RX_TIMEOUT_EN
  assign timeout   = r_timeout;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rx_word_collector.sv
// Scoreboard bench for rx_word_collector: random byte words plus directed framing,
// zero-length, timeout and reset cases.
module tb_rx_word_collector;

  localparam int CPB = 16;
  localparam int TO  = 1000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        RxD   = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  bytes = 3'd0;
  logic        busy, valid, frame_err, timeout;
  logic [31:0] word;

  always #5 clk = ~clk;

  rx_word_collector #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RxD       (RxD),
    .start     (start),
    .bytes     (bytes),
    .busy      (busy),
    .word      (word),
    .valid     (valid),
    .frame_err (frame_err),
    .timeout   (timeout)
  );

  // kind: 0 = valid, 1 = frame_err, 2 = timeout
  typedef struct {
    int          kind;
    logic [31:0] word;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [31:0] model_word = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event pops one expectation.
  always @(negedge clk) begin : monitor
    int   k;
    exp_t e;
    if (rst_n && (valid || frame_err || timeout)) begin
      k = valid ? 0 : (frame_err ? 1 : 2);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got kind %0d word 0x%08h, expected no event (cycle %0d)", k, word, cyc);
      end else begin
        e = sb.pop_front();
        check("event_kind", k, e.kind);
        check("word", word, e.word);
        check("busy_at_event", {31'd0, busy}, 32'd0);
        if (e.lat >= 0) check("latency", cyc - e.t0, e.lat);
        $display("txn kind=%0d word=0x%08h cycle=%0d", k, word, cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_bit);
    RxD = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (CPB) @(negedge clk);
    end
    RxD = stop_bit;
    repeat (CPB) @(negedge clk);
    RxD = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  // kind < 0: issue start without expecting any event.
  task automatic do_start(input logic [2:0] n, input int kind, input logic [31:0] w, input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    bytes = n;
    if (kind >= 0) begin
      e.kind = kind; e.word = w; e.lat = lat; e.t0 = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    bytes = 3'($urandom);
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_drain(input int bound);
    int i = 0;
    while (sb.size() != 0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending events, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic word_txn(input logic [2:0] n, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input bit poke_busy);
    logic [7:0]  bv[4];
    int          c;
    logic [31:0] w;
    bv[0] = b0; bv[1] = b1; bv[2] = b2; bv[3] = b3;
    c = (n > 3'd4) ? 4 : int'(n);
    w = 32'd0;
    for (int i = 0; i < c; i++) w = w + (32'(bv[i]) << (8 * i));
    model_word = w;
    do_start(n, 0, w, (c == 0) ? 3 : -1);
    for (int i = 0; i < c; i++) begin
      if (i == 0 && poke_busy) begin
        @(negedge clk); start = 1'b1; bytes = 3'd1;
        @(negedge clk); start = 1'b0;
      end
      send_byte(bv[i], 1'b1);
    end
    wait_drain(400);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [2:0] n;
    repeat (4) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_word", word, 32'd0);
    check("reset_pulses", {29'd0, valid, frame_err, timeout}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    word_txn(3'd4, 8'h78, 8'h56, 8'h34, 8'h12, 1'b0);
    word_txn(3'd2, 8'hAB, 8'hCD, 8'h00, 8'h00, 1'b0);
    word_txn(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    word_txn(3'd7, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);

    // Stop-bit error on the second byte: word keeps its previous value.
    do_start(3'd3, 1, model_word, -1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    wait_drain(400);

    for (int t = 0; t < 12; t++) begin
      n = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b1);
      word_txn(n, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               (n != 3'd0) && ($urandom_range(0, 2) == 0));
    end

`ifdef RX_TIMEOUT_EN
    do_start(3'd2, 2, model_word, -1);
    send_byte(8'h5A, 1'b1);
    wait_drain(1500);
`else
    model_word = 32'h0000C35A;
    do_start(3'd2, 0, model_word, -1);
    send_byte(8'h5A, 1'b1);
    repeat (1500) @(negedge clk);
    check("still_busy_no_timeout", {31'd0, busy}, 32'd1);
    check("no_early_event", sb.size(), 32'd1);
    send_byte(8'hC3, 1'b1);
    wait_drain(400);
`endif

    // False-start glitch while armed, then reset in the middle of a real byte.
    do_start(3'd2, -1, 32'd0, -1);
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    RxD = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_still_busy", {31'd0, busy}, 32'd1);
    RxD = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_word", word, 32'd0);
    check("rst_pulses", {29'd0, valid, frame_err, timeout}, 32'd0);
    RxD = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("post_reset_idle", {31'd0, busy}, 32'd0);

    word_txn(3'd1, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
